fifo_seq: RTL

Sequencer for the 8-longword SCSI/host data FIFO. It accepts byte strobes from the SCSI side and longword completions from the host bus side, and generates the FIFO pointer and byte-offset increment pulses. It keeps the occupancy count that drives FIFOFULL/FIFOEMPTY, and handles flush of a partial final longword. It sits between the DMA state machine and the FIFO storage/pointer block, which consumes its INC* pulses.

---
 rtl/fifo_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_seq.sv
// Sequencer for the 8-longword SCSI/host data FIFO: byte offset, longword occupancy,
// pointer/occupancy increment pulses and partial-word flush handling.
module fifo_seq #(
  parameter int THRESH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DMADIR,
  input  logic       CLR,
  input  logic       SCSI_STB,
  input  logic       BUS_ACK,
  input  logic       FLUSH,
  output logic       SCSI_RDY,
  output logic       BUS_REQ,
  output logic       INCNI,
  output logic       INCNO,
  output logic       INCFIFO,
  output logic       DECFIFO,
  output logic       INCBO,
  output logic [1:0] BO,
  output logic [3:0] WCNT,
  output logic       FIFOFULL,
  output logic       FIFOEMPTY,
  output logic       FLUSHDONE
);

  localparam logic [3:0] THRESH_W = 4'(THRESH);

  logic [3:0] wcnt_q, wcnt_d;
  logic [1:0] bo_q, bo_d;
  logic       flush_pend_q, flush_pend_d;
  logic       dmadir_q;
  logic       incni_d, incno_d, incfifo_d, decfifo_d, incbo_d, flushdone_d;
  logic       clr, byte_acc, word_acc, pad, flush_done_c;

  assign WCNT      = wcnt_q;
  assign BO        = bo_q;
  assign FIFOFULL  = (wcnt_q == 4'd8);
  assign FIFOEMPTY = (wcnt_q == 4'd0);

  // Handshake: a byte moves in any cycle where SCSI_STB && SCSI_RDY are both high;
  // SCSI_STB with SCSI_RDY low is dropped, not held. BUS_ACK is a one-cycle completion
  // that is only honoured when the FIFO can take or give a longword in that direction.
  assign SCSI_RDY = DMADIR ? !FIFOEMPTY : (!FIFOFULL && !flush_pend_q);
  assign BUS_REQ  = DMADIR ? (((4'd8 - wcnt_q) >= THRESH_W) && !FIFOFULL)
                           : ((wcnt_q >= THRESH_W) || (flush_pend_q && !FIFOEMPTY));

  always_comb begin
    clr          = CLR || (DMADIR != dmadir_q);
    byte_acc     = SCSI_STB && SCSI_RDY;
    word_acc     = BUS_ACK && (DMADIR ? !FIFOFULL : !FIFOEMPTY);
    pad          = !DMADIR && flush_pend_q && (bo_q != 2'd0);
    flush_done_c = flush_pend_q && (bo_q == 2'd0) && FIFOEMPTY;

    incni_d      = 1'b0;
    incno_d      = 1'b0;
    incfifo_d    = 1'b0;
    decfifo_d    = 1'b0;
    incbo_d      = 1'b0;
    flushdone_d  = 1'b0;
    bo_d         = bo_q;
    flush_pend_d = flush_pend_q;

    if (clr) begin
      bo_d         = 2'd0;
      flush_pend_d = 1'b0;
    end else begin
      if (byte_acc) begin
        incbo_d = 1'b1;
        bo_d    = bo_q + 2'd1;
        if (bo_q == 2'd3) begin
          if (DMADIR) begin
            incno_d   = 1'b1;
            decfifo_d = 1'b1;
          end else begin
            incni_d   = 1'b1;
            incfifo_d = 1'b1;
          end
        end
      end
      // Padding closes the partial longword; SCSI_RDY is low while a flush is
      // pending, so this never collides with a byte completing a word.
      if (pad) begin
        incni_d   = 1'b1;
        incfifo_d = 1'b1;
        bo_d      = 2'd0;
      end
      if (word_acc) begin
        if (DMADIR) begin
          incni_d   = 1'b1;
          incfifo_d = 1'b1;
        end else begin
          incno_d   = 1'b1;
          decfifo_d = 1'b1;
        end
      end
      if (FLUSH && !DMADIR) flush_pend_d = 1'b1;
      if (flush_done_c) begin
        flush_pend_d = 1'b0;
        flushdone_d  = 1'b1;
      end
    end

    case ({incfifo_d, decfifo_d})
      2'b10:   wcnt_d = wcnt_q + 4'd1;
      2'b01:   wcnt_d = wcnt_q - 4'd1;
      default: wcnt_d = wcnt_q;
    endcase
    if (clr) wcnt_d = 4'd0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q       <= 4'd0;
      bo_q         <= 2'd0;
      flush_pend_q <= 1'b0;
      dmadir_q     <= 1'b0;
      INCNI        <= 1'b0;
      INCNO        <= 1'b0;
      INCFIFO      <= 1'b0;
      DECFIFO      <= 1'b0;
      INCBO        <= 1'b0;
      FLUSHDONE    <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      bo_q         <= bo_d;
      flush_pend_q <= flush_pend_d;
      dmadir_q     <= DMADIR;
      INCNI        <= incni_d;
      INCNO        <= incno_d;
      INCFIFO      <= incfifo_d;
      DECFIFO      <= decfifo_d;
      INCBO        <= incbo_d;
      FLUSHDONE    <= flushdone_d;
    end
  end

endmodule
